spi_arbiter: RTL and testbench

SPI_ARBITER -- requirements
Module: spi_arbiter

---
 rtl/spi_pkg.sv | 20 ++
 rtl/spi_clkgen.sv | 41 ++++
 rtl/spi_arbiter.sv | 135 +++++++++++++
 tb/tb_spi_arbiter.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI arbiter: FSM state encoding, frame width,
// requester count and the owner-to-one-hot helper.
package spi_pkg;

  localparam int FRAME_W = 8;
  localparam int NUM_REQ = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_DONE,
    ST_GAP
  } state_t;

  function automatic logic [NUM_REQ-1:0] ownerOneHot(input logic owner);
    return owner ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/spi_clkgen.sv
// SCLK generator: counts DIV_HALF clk cycles per half-period and emits
// rise/fall strobes one cycle ahead of the registered sclk edge.
module spi_clkgen #(
  parameter int DIV_HALF = 2
) (
  input  logic clk,
  input  logic b0,
  input  logic i_en,
  output logic o_sclk,
  output logic o_rise,
  output logic o_fall
);

  localparam logic [7:0] DIV_M1 = 8'(DIV_HALF - 1);

  logic [7:0] r_cnt;
  logic       r_sclk;
  logic       w_tick;

  assign w_tick = i_en && (r_cnt == DIV_M1);
  assign o_rise = w_tick && !r_sclk;
  assign o_fall = w_tick && r_sclk;
  assign o_sclk = r_sclk;

  // Disabling clears both the phase counter and sclk so every frame starts low.
  always_ff @(posedge clk or negedge b0) begin
    if (!b0) begin
      r_cnt  <= 8'd0;
      r_sclk <= 1'b0;
    end else if (!i_en) begin
      r_cnt  <= 8'd0;
      r_sclk <= 1'b0;
    end else if (w_tick) begin
      r_cnt  <= 8'd0;
      r_sclk <= ~r_sclk;
    end else begin
      r_cnt  <= r_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/spi_arbiter.sv
// Two-requester SPI mode-0 master with arbitration, LSB-first 8-bit frames.
// Define SPI_ARB_RR_EN for round-robin ties; default is fixed priority to req[0].
module spi_arbiter
  import spi_pkg::*;
#(
  parameter int DIV_HALF = 2,
  parameter int GAP      = 2
) (
  input  logic               clk,
  input  logic               b0,
  input  logic [NUM_REQ-1:0] req,
  input  logic [FRAME_W-1:0] tx_data0,
  input  logic [FRAME_W-1:0] tx_data1,
  output logic [NUM_REQ-1:0] gnt,
  output logic [NUM_REQ-1:0] done,
  output logic [FRAME_W-1:0] rx_data,
  output logic               busy,
  output logic               sclk,
  output logic               cs,
  output logic               mosi,
  input  logic               miso
);

  localparam logic [7:0] GAP_M1   = 8'(GAP - 1);
  localparam logic [2:0] LAST_BIT = 3'(FRAME_W - 1);

  state_t             r_state;
  state_t             w_nextState;
  logic               r_owner;
  logic               w_winner;
  logic [FRAME_W-1:0] r_tx;
  logic [FRAME_W-1:0] r_rx;
  logic [FRAME_W-1:0] r_rxData;
  logic [2:0]         r_bitCnt;
  logic [7:0]         r_gapCnt;
  logic               w_shiftEn;
  logic               w_start;
  logic               w_rise;
  logic               w_fall;
  logic               w_sclk;

  assign w_start   = (r_state == ST_IDLE) && (|req);
  assign w_shiftEn = (r_state == ST_SETUP) || (r_state == ST_SHIFT);

`ifdef SPI_ARB_RR_EN
  logic r_ptr;

  // Pointer names the preferred requester for the next tie.
  assign w_winner = (&req) ? r_ptr : req[1];

  always_ff @(posedge clk or negedge b0) begin
    if (!b0) begin
      r_ptr <= 1'b0;
    end else if (w_start) begin
      r_ptr <= ~w_winner;
    end
  end
`else
  assign w_winner = !req[0];
`endif

  spi_clkgen #(
    .DIV_HALF(DIV_HALF)
  ) u_clkgen (
    .clk   (clk),
    .b0    (b0),
    .i_en  (w_shiftEn),
    .o_sclk(w_sclk),
    .o_rise(w_rise),
    .o_fall(w_fall)
  );

  always_ff @(posedge clk or negedge b0) begin
    if (!b0) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE:  if (|req) w_nextState = ST_SETUP;
      ST_SETUP: if (w_rise) w_nextState = ST_SHIFT;
      ST_SHIFT: if (w_fall && (r_bitCnt == LAST_BIT)) w_nextState = ST_DONE;
      ST_DONE:  w_nextState = ST_GAP;
      ST_GAP:   if (r_gapCnt == GAP_M1) w_nextState = ST_IDLE;
      default:  w_nextState = ST_IDLE;
    endcase
  end

  // The 8th falling edge ends the frame, so the bit counter wraps only there.
  always_ff @(posedge clk or negedge b0) begin
    if (!b0) begin
      r_owner  <= 1'b0;
      r_tx     <= '0;
      r_rx     <= '0;
      r_rxData <= '0;
      r_bitCnt <= 3'd0;
      r_gapCnt <= 8'd0;
    end else begin
      if (w_start) begin
        r_owner  <= w_winner;
        r_tx     <= w_winner ? tx_data1 : tx_data0;
        r_bitCnt <= 3'd0;
      end
      if (w_rise) begin
        r_rx[r_bitCnt] <= miso;
      end
      if (w_fall) begin
        if (r_bitCnt == LAST_BIT) begin
          r_bitCnt <= 3'd0;
          r_rxData <= r_rx;
        end else begin
          r_bitCnt <= r_bitCnt + 3'd1;
        end
      end
      if (r_state == ST_GAP) begin
        r_gapCnt <= r_gapCnt + 8'd1;
      end else begin
        r_gapCnt <= 8'd0;
      end
    end
  end

  assign busy    = (r_state != ST_IDLE);
  assign cs      = !w_shiftEn;
  assign gnt     = w_shiftEn ? ownerOneHot(r_owner) : '0;
  assign done    = (r_state == ST_DONE) ? ownerOneHot(r_owner) : '0;
  assign mosi    = w_shiftEn ? r_tx[r_bitCnt] : 1'b0;
  assign sclk    = w_sclk;
  assign rx_data = r_rxData;

endmodule

// File: tb/tb_spi_arbiter.sv
// Directed self-checking bench for spi_arbiter: one DUT at DIV_HALF=2 and one
// at DIV_HALF=1; tie expectations follow SPI_ARB_RR_EN when it is defined.
module tb_spi_arbiter;

  localparam int GAP_C = 2;

  typedef struct {
    logic [1:0] gnt1;
    logic       cs1;
    logic       mosi1;
    logic       busy1;
    int         firstRise;
    int         secondRise;
    int         rises;
    logic [7:0] mosiByte;
    logic       mosiHigh;
    int         doneCyc;
    logic [1:0] doneVal;
    logic [7:0] rx;
    logic [1:0] doneAfter;
  } frame_t;

  logic       clk = 1'b0;
  logic       b0;
  logic [1:0] reqA;
  logic [1:0] reqB;
  logic [7:0] txData0;
  logic [7:0] txData1;
  logic       loopEn;
  logic       misoVal;
  logic       watchSel;

  logic [1:0] gnt0, done0, gnt1, done1;
  logic [7:0] rx0, rx1;
  logic       busy0, sclk0, cs0, mosi0, miso0;
  logic       busy1, sclk1, cs1, mosi1, miso1;

  logic [1:0] wGnt, wDone;
  logic [7:0] wRx;
  logic       wBusy, wSclk, wCs, wMosi;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign miso0 = loopEn ? mosi0 : misoVal;
  assign miso1 = mosi1;

  assign wGnt  = watchSel ? gnt1  : gnt0;
  assign wDone = watchSel ? done1 : done0;
  assign wRx   = watchSel ? rx1   : rx0;
  assign wBusy = watchSel ? busy1 : busy0;
  assign wSclk = watchSel ? sclk1 : sclk0;
  assign wCs   = watchSel ? cs1   : cs0;
  assign wMosi = watchSel ? mosi1 : mosi0;

  spi_arbiter #(.DIV_HALF(2), .GAP(GAP_C)) dut0 (
    .clk(clk), .b0(b0), .req(reqA), .tx_data0(txData0), .tx_data1(txData1),
    .gnt(gnt0), .done(done0), .rx_data(rx0), .busy(busy0),
    .sclk(sclk0), .cs(cs0), .mosi(mosi0), .miso(miso0)
  );

  spi_arbiter #(.DIV_HALF(1), .GAP(GAP_C)) dut1 (
    .clk(clk), .b0(b0), .req(reqB), .tx_data0(txData0), .tx_data1(txData1),
    .gnt(gnt1), .done(done1), .rx_data(rx1), .busy(busy1),
    .sclk(sclk1), .cs(cs1), .mosi(mosi1), .miso(miso1)
  );

  // Called at a negedge right after driving a request; k=1 is the first cycle after arbitration.
  task automatic watchFrame(input int maxCyc, output frame_t f);
    logic prevSclk;
    f.gnt1 = '0; f.cs1 = 1'b0; f.mosi1 = 1'b0; f.busy1 = 1'b0;
    f.firstRise = 0; f.secondRise = 0; f.rises = 0; f.mosiByte = '0;
    f.mosiHigh = 1'b0; f.doneCyc = 0; f.doneVal = '0; f.rx = '0; f.doneAfter = '1;
    prevSclk = 1'b0;
    @(posedge clk);
    for (int k = 1; k <= maxCyc; k++) begin
      @(negedge clk);
      if (k == 1) begin
        f.gnt1 = wGnt; f.cs1 = wCs; f.mosi1 = wMosi; f.busy1 = wBusy;
      end
      if (wSclk && !prevSclk) begin
        f.rises++;
        if (f.rises == 1) f.firstRise = k;
        if (f.rises == 2) f.secondRise = k;
        if (f.rises <= 8) f.mosiByte[3'(f.rises - 1)] = wMosi;
      end
      if (wMosi) f.mosiHigh = 1'b1;
      prevSclk = wSclk;
      if (f.doneCyc != 0 && k == f.doneCyc + 1) begin
        f.doneAfter = wDone;
        break;
      end
      if (wDone != 2'b00 && f.doneCyc == 0) begin
        f.doneCyc = k;
        f.doneVal = wDone;
        f.rx      = wRx;
        if (watchSel) reqB = 2'b00;
        else reqA = 2'b00;
      end
    end
  endtask

  task automatic test_reset;
    b0 = 1'b0;
    reqA = 2'b01;
    repeat (3) @(negedge clk);
    checks++; if (cs0 !== 1'b1) begin errors++; $display("[TB] FAIL reset_cs got=%b exp=1", cs0); end
    checks++; if (sclk0 !== 1'b0) begin errors++; $display("[TB] FAIL reset_sclk got=%b exp=0", sclk0); end
    checks++; if (mosi0 !== 1'b0) begin errors++; $display("[TB] FAIL reset_mosi got=%b exp=0", mosi0); end
    checks++; if (gnt0 !== 2'b00) begin errors++; $display("[TB] FAIL reset_gnt got=%b exp=00", gnt0); end
    checks++; if (done0 !== 2'b00) begin errors++; $display("[TB] FAIL reset_done got=%b exp=00", done0); end
    checks++; if (busy0 !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got=%b exp=0", busy0); end
    checks++; if (rx0 !== 8'h00) begin errors++; $display("[TB] FAIL reset_rx got=%h exp=00", rx0); end
    reqA = 2'b00;
    @(negedge clk);
    b0 = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_frame;
    frame_t f;
    watchSel = 1'b0;
    loopEn   = 1'b1;
    txData0  = 8'hA5;
    reqA     = 2'b01;
    watchFrame(60, f);
    checks++; if (f.gnt1 !== 2'b01) begin errors++; $display("[TB] FAIL single_gnt got=%b exp=01", f.gnt1); end
    checks++; if (f.cs1 !== 1'b0) begin errors++; $display("[TB] FAIL single_cs got=%b exp=0", f.cs1); end
    checks++; if (f.mosi1 !== 1'b1) begin errors++; $display("[TB] FAIL single_mosi_bit0 got=%b exp=1", f.mosi1); end
    checks++; if (f.busy1 !== 1'b1) begin errors++; $display("[TB] FAIL single_busy got=%b exp=1", f.busy1); end
    checks++; if (f.firstRise != 3) begin errors++; $display("[TB] FAIL single_first_rise got=%0d exp=3", f.firstRise); end
    checks++; if (f.rises != 8) begin errors++; $display("[TB] FAIL single_rises got=%0d exp=8", f.rises); end
    checks++; if (f.mosiByte !== 8'hA5) begin errors++; $display("[TB] FAIL single_mosi_bits got=%h exp=a5", f.mosiByte); end
    checks++; if (f.doneCyc != 33) begin errors++; $display("[TB] FAIL single_done_cycle got=%0d exp=33", f.doneCyc); end
    checks++; if (f.doneVal !== 2'b01) begin errors++; $display("[TB] FAIL single_done_val got=%b exp=01", f.doneVal); end
    checks++; if (f.rx !== 8'hA5) begin errors++; $display("[TB] FAIL single_rx got=%h exp=a5", f.rx); end
    checks++; if (f.doneAfter !== 2'b00) begin errors++; $display("[TB] FAIL single_done_width got=%b exp=00", f.doneAfter); end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_miso_ones;
    frame_t f;
    watchSel = 1'b0;
    loopEn   = 1'b0;
    misoVal  = 1'b1;
    txData0  = 8'h00;
    reqA     = 2'b01;
    watchFrame(60, f);
    checks++; if (f.rx !== 8'hFF) begin errors++; $display("[TB] FAIL ones_rx got=%h exp=ff", f.rx); end
    checks++; if (f.mosiHigh !== 1'b0) begin errors++; $display("[TB] FAIL ones_mosi_const got=%b exp=0", f.mosiHigh); end
    checks++; if (f.rises != 8) begin errors++; $display("[TB] FAIL ones_rises got=%0d exp=8", f.rises); end
    checks++; if (f.doneCyc != 33) begin errors++; $display("[TB] FAIL ones_done_cycle got=%0d exp=33", f.doneCyc); end
    loopEn = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  // Five frames: four with both requests held, then req[0] dropped for the fifth.
  task automatic test_tie;
    logic [1:0] expG [5];
    logic [1:0] grants [5];
    logic [1:0] doneVals [5];
    logic [7:0] rxs [5];
    int         gaps [4];
    int         nGrant, nDone, nGap, gapLen, badGnt, badMosi;
    logic       inGap;
    logic [1:0] prevGnt;
`ifdef SPI_ARB_RR_EN
    expG = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b10};
`else
    expG = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
`endif
    for (int i = 0; i < 5; i++) begin grants[i] = '0; doneVals[i] = '0; rxs[i] = '0; end
    for (int i = 0; i < 4; i++) gaps[i] = 0;
    nGrant = 0; nDone = 0; nGap = 0; gapLen = 0; badGnt = 0; badMosi = 0;
    inGap = 1'b0; prevGnt = 2'b00;
    loopEn  = 1'b1;
    txData0 = 8'h01;
    txData1 = 8'h80;
    reqA    = 2'b11;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (gnt0 != 2'b00 && prevGnt == 2'b00) begin
        if (nGrant < 5) grants[nGrant] = gnt0;
        nGrant++;
      end
      if (gnt0 == 2'b11) badGnt++;
      if (cs0 && mosi0) badMosi++;
      if (inGap) begin
        if (cs0) gapLen++;
        else begin
          if (nGap < 4) gaps[nGap] = gapLen;
          nGap++;
          inGap = 1'b0;
        end
      end
      prevGnt = gnt0;
      if (done0 != 2'b00) begin
        doneVals[nDone] = done0;
        rxs[nDone] = rx0;
        nDone++;
        if (nDone < 5) begin inGap = 1'b1; gapLen = 0; end
        if (nDone == 4) reqA = 2'b10;
        if (nDone == 5) begin reqA = 2'b00; break; end
      end
    end
    checks++; if (nDone != 5) begin errors++; $display("[TB] FAIL tie_frame_count got=%0d exp=5", nDone); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (grants[i] !== expG[i]) begin errors++; $display("[TB] FAIL tie_grant%0d got=%b exp=%b", i, grants[i], expG[i]); end
      checks++; if (doneVals[i] !== expG[i]) begin errors++; $display("[TB] FAIL tie_done%0d got=%b exp=%b", i, doneVals[i], expG[i]); end
      checks++; if (rxs[i] !== ((expG[i] == 2'b01) ? 8'h01 : 8'h80)) begin errors++; $display("[TB] FAIL tie_rx%0d got=%h exp=%h", i, rxs[i], (expG[i] == 2'b01) ? 8'h01 : 8'h80); end
    end
    for (int i = 0; i < 4; i++) begin
      checks++; if (gaps[i] != GAP_C + 1) begin errors++; $display("[TB] FAIL tie_gap%0d got=%0d exp=%0d", i, gaps[i], GAP_C + 1); end
    end
    checks++; if (badGnt != 0) begin errors++; $display("[TB] FAIL tie_onehot got=%0d exp=0", badGnt); end
    checks++; if (badMosi != 0) begin errors++; $display("[TB] FAIL tie_mosi_cs got=%0d exp=0", badMosi); end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_div1;
    frame_t f;
    watchSel = 1'b1;
    txData1  = 8'h3C;
    reqB     = 2'b10;
    watchFrame(40, f);
    checks++; if (f.gnt1 !== 2'b10) begin errors++; $display("[TB] FAIL div1_gnt got=%b exp=10", f.gnt1); end
    checks++; if (f.doneCyc != 17) begin errors++; $display("[TB] FAIL div1_done_cycle got=%0d exp=17", f.doneCyc); end
    checks++; if (f.doneVal !== 2'b10) begin errors++; $display("[TB] FAIL div1_done_val got=%b exp=10", f.doneVal); end
    checks++; if (f.rx !== 8'h3C) begin errors++; $display("[TB] FAIL div1_rx got=%h exp=3c", f.rx); end
    checks++; if (f.firstRise != 2) begin errors++; $display("[TB] FAIL div1_first_rise got=%0d exp=2", f.firstRise); end
    checks++; if (f.secondRise - f.firstRise != 2) begin errors++; $display("[TB] FAIL div1_sclk_period got=%0d exp=2", f.secondRise - f.firstRise); end
    checks++; if (f.rises != 8) begin errors++; $display("[TB] FAIL div1_rises got=%0d exp=8", f.rises); end
    watchSel = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset_midframe;
    frame_t f;
    int     rises, doneSeen;
    logic   prevSclk, hit;
    rises = 0; doneSeen = 0; prevSclk = 1'b0; hit = 1'b0;
    watchSel = 1'b0;
    loopEn   = 1'b1;
    txData0  = 8'h5A;
    reqA     = 2'b01;
    @(posedge clk);
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (done0 != 2'b00) doneSeen++;
      if (sclk0 && !prevSclk) rises++;
      prevSclk = sclk0;
      if (rises == 4) begin hit = 1'b1; break; end
    end
    checks++; if (hit !== 1'b1) begin errors++; $display("[TB] FAIL abort_reach_rise4 got=%b exp=1", hit); end
    b0 = 1'b0;
    #1;
    checks++; if (cs0 !== 1'b1) begin errors++; $display("[TB] FAIL abort_cs got=%b exp=1", cs0); end
    checks++; if (sclk0 !== 1'b0) begin errors++; $display("[TB] FAIL abort_sclk got=%b exp=0", sclk0); end
    checks++; if (gnt0 !== 2'b00) begin errors++; $display("[TB] FAIL abort_gnt got=%b exp=00", gnt0); end
    checks++; if (busy0 !== 1'b0) begin errors++; $display("[TB] FAIL abort_busy got=%b exp=0", busy0); end
    checks++; if (rx0 !== 8'h00) begin errors++; $display("[TB] FAIL abort_rx got=%h exp=00", rx0); end
    reqA = 2'b00;
    repeat (5) begin
      @(negedge clk);
      if (done0 != 2'b00) doneSeen++;
    end
    b0 = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (done0 != 2'b00) doneSeen++;
    end
    checks++; if (doneSeen != 0) begin errors++; $display("[TB] FAIL abort_no_done got=%0d exp=0", doneSeen); end
    txData0 = 8'h3C;
    reqA    = 2'b01;
    watchFrame(60, f);
    checks++; if (f.doneCyc != 33) begin errors++; $display("[TB] FAIL after_abort_done_cycle got=%0d exp=33", f.doneCyc); end
    checks++; if (f.doneVal !== 2'b01) begin errors++; $display("[TB] FAIL after_abort_done_val got=%b exp=01", f.doneVal); end
    checks++; if (f.rx !== 8'h3C) begin errors++; $display("[TB] FAIL after_abort_rx got=%h exp=3c", f.rx); end
    repeat (4) @(negedge clk);
  endtask

  initial begin
    b0 = 1'b0; reqA = 2'b00; reqB = 2'b00;
    txData0 = 8'h00; txData1 = 8'h00;
    loopEn = 1'b1; misoVal = 1'b0; watchSel = 1'b0;
    test_reset();
    test_single_frame();
    test_miso_ones();
    test_tie();
    test_div1();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
